// File: rtl/zoom_gesture_ctrl.sv
// zoom_gesture_ctrl: pinch-gesture sequencer in front of the zoom scale-factor unit.
// Captures the two-finger start/end points, rejects moves inside the deadzone, decides
// the zoom direction, holds coordinates stable across the FP divide pipeline, then
// pulses oREADY for one cycle. Only one zoom request is in flight at a time.
// Optional feature: define ZOOM_TIMEOUT_EN to abort a gesture after TIMEOUT idle cycles
// in TRACK (oABORT pulses); without it TRACK waits indefinitely and oABORT is tied 0.
// Handshake: iTOUCH_VALID is a one-cycle strobe with no back-pressure; samples that
//   arrive outside IDLE/TRACK are dropped. oREADY is a one-cycle strobe to the scale
//   unit, asserted only after coordinates have been stable for PIPE_LAT cycles.
module zoom_gesture_ctrl #(
    parameter logic [5:0]  PIPE_LAT = 6'd24,
    parameter logic [2:0]  COOL_LAT = 3'd3,
    parameter logic [10:0] DEADZONE = 11'd16,
    parameter logic [23:0] TIMEOUT  = 24'd5000000
) (
    input  logic       iCLK,
    input  logic       iRSTN,
    input  logic       iTOUCH_VALID,
    input  logic [1:0] iTOUCH_COUNT,
    input  logic [9:0] iX1,
    input  logic [9:0] iX2,
    input  logic [8:0] iY1,
    input  logic [8:0] iY2,
    output logic [9:0] oX1_START,
    output logic [9:0] oX2_START,
    output logic [8:0] oY1_START,
    output logic [8:0] oY2_START,
    output logic [9:0] oX1_END,
    output logic [9:0] oX2_END,
    output logic [8:0] oY1_END,
    output logic [8:0] oY2_END,
    output logic       oZOOM_OUT,
    output logic       oREADY,
    output logic       oBUSY,
    output logic       oABORT
);

    typedef enum logic [2:0] {
        S_IDLE, S_TRACK, S_CALC, S_SETTLE, S_ISSUE, S_COOL
    } state_t;

    localparam logic [5:0] COOL_END = {3'b000, COOL_LAT} - 6'd1;
    localparam logic [5:0] PIPE_END = PIPE_LAT - 6'd1;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [9:0]  x1s_q, x2s_q, x1e_q, x2e_q;
    logic [8:0]  y1s_q, y2s_q, y1e_q, y2e_q;
    logic        zoom_out_q;
    logic        ready_q;

    logic [10:0]        span_s, span_e;
    logic signed [11:0] span_diff;
    logic [11:0]        span_mag;
    logic               reject;
    logic               two_finger;

    function automatic logic [9:0] absd10(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [8:0] absd9(input logic [8:0] a, input logic [8:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    assign two_finger = iTOUCH_VALID && (iTOUCH_COUNT == 2'd2);

    // Manhattan spans of the latched start/end points and the deadzone decision.
    always_comb begin
        span_s    = {1'b0, absd10(x1s_q, x2s_q)} + {2'b00, absd9(y1s_q, y2s_q)};
        span_e    = {1'b0, absd10(x1e_q, x2e_q)} + {2'b00, absd9(y1e_q, y2e_q)};
        span_diff = $signed({1'b0, span_e}) - $signed({1'b0, span_s});
        span_mag  = span_diff[11] ? 12'(-span_diff) : 12'(span_diff);
        // Equal spans never issue a request, even with a zero deadzone.
        reject    = (span_mag < {1'b0, DEADZONE}) || (span_diff == 12'sd0);
    end

`ifdef ZOOM_TIMEOUT_EN
    logic [23:0] idle_q;
    logic        abort_q;
    assign oABORT = abort_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign oABORT = 1'b0;
`endif

    // Gesture sequencer: state, counters, coordinate latches and registered strobes.
    always_ff @(posedge iCLK) begin
        if (!iRSTN) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            x1s_q      <= '0;
            x2s_q      <= '0;
            y1s_q      <= '0;
            y2s_q      <= '0;
            x1e_q      <= '0;
            x2e_q      <= '0;
            y1e_q      <= '0;
            y2e_q      <= '0;
            zoom_out_q <= 1'b0;
            ready_q    <= 1'b0;
`ifdef ZOOM_TIMEOUT_EN
            idle_q     <= '0;
            abort_q    <= 1'b0;
`endif
        end else begin
            ready_q <= 1'b0;
`ifdef ZOOM_TIMEOUT_EN
            abort_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (two_finger) begin
                        x1s_q   <= iX1;
                        x2s_q   <= iX2;
                        y1s_q   <= iY1;
                        y2s_q   <= iY2;
                        x1e_q   <= iX1;
                        x2e_q   <= iX2;
                        y1e_q   <= iY1;
                        y2e_q   <= iY2;
                        state_q <= S_TRACK;
`ifdef ZOOM_TIMEOUT_EN
                        idle_q  <= '0;
`endif
                    end
                end
                S_TRACK: begin
                    if (iTOUCH_VALID) begin
                        if (iTOUCH_COUNT == 2'd2) begin
                            x1e_q <= iX1;
                            x2e_q <= iX2;
                            y1e_q <= iY1;
                            y2e_q <= iY2;
                        end else begin
                            // Finger lift (or a third finger) closes the gesture.
                            state_q <= S_CALC;
                        end
`ifdef ZOOM_TIMEOUT_EN
                        idle_q <= '0;
                    end else if (idle_q == TIMEOUT - 24'd1) begin
                        state_q <= S_IDLE;
                        abort_q <= 1'b1;
                    end else begin
                        idle_q <= idle_q + 24'd1;
`endif
                    end
                end
                S_CALC: begin
                    if (reject) begin
                        state_q <= S_IDLE;
                    end else begin
                        zoom_out_q <= (span_e < span_s);
                        cnt_q      <= '0;
                        state_q    <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == PIPE_END) begin
                        ready_q <= 1'b1;
                        state_q <= S_ISSUE;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                S_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= S_COOL;
                end
                S_COOL: begin
                    if (cnt_q == COOL_END) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign oX1_START = x1s_q;
    assign oX2_START = x2s_q;
    assign oY1_START = y1s_q;
    assign oY2_START = y2s_q;
    assign oX1_END   = x1e_q;
    assign oX2_END   = x2e_q;
    assign oY1_END   = y1e_q;
    assign oY2_END   = y2e_q;
    assign oZOOM_OUT = zoom_out_q;
    assign oREADY    = ready_q;
    assign oBUSY     = (state_q != S_IDLE);

endmodule

// File: tb/tb_zoom_gesture_ctrl.sv
// Testbench for zoom_gesture_ctrl: directed gestures, scoreboard of expected
// zoom requests (direction + held coordinates) checked whenever oREADY fires.
module tb_zoom_gesture_ctrl;

    localparam int PIPE_LAT = 24;
    localparam int COOL_LAT = 3;
    localparam int DEADZONE = 16;
    localparam int TIMEOUT  = 100;
    localparam int W        = 77;

    logic       clk;
    logic       rstn;
    logic       touch_valid;
    logic [1:0] touch_count;
    logic [9:0] x1, x2;
    logic [8:0] y1, y2;
    logic [9:0] x1s, x2s, x1e, x2e;
    logic [8:0] y1s, y2s, y1e, y2e;
    logic       zoom_out, ready, busy, abort_o;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [W-1:0] exp_q[$];
    logic prev_ready = 1'b0;

    zoom_gesture_ctrl #(
        .PIPE_LAT(6'(PIPE_LAT)),
        .COOL_LAT(3'(COOL_LAT)),
        .DEADZONE(11'(DEADZONE)),
        .TIMEOUT (24'(TIMEOUT))
    ) dut (
        .iCLK        (clk),
        .iRSTN       (rstn),
        .iTOUCH_VALID(touch_valid),
        .iTOUCH_COUNT(touch_count),
        .iX1         (x1),
        .iX2         (x2),
        .iY1         (y1),
        .iY2         (y2),
        .oX1_START   (x1s),
        .oX2_START   (x2s),
        .oY1_START   (y1s),
        .oY2_START   (y2s),
        .oX1_END     (x1e),
        .oX2_END     (x2e),
        .oY1_END     (y1e),
        .oY2_END     (y2e),
        .oZOOM_OUT   (zoom_out),
        .oREADY      (ready),
        .oBUSY       (busy),
        .oABORT      (abort_o)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] pack_out();
        return {zoom_out, x1s, x2s, y1s, y2s, x1e, x2e, y1e, y2e};
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference model: expected request payload and whether a request is due.
    function automatic logic [W-1:0] model(input int sx1, sy1, sx2, sy2,
                                           input int ex1, ey1, ex2, ey2,
                                           output bit req);
        int ss, se, d;
        ss  = iabs(sx1 - sx2) + iabs(sy1 - sy2);
        se  = iabs(ex1 - ex2) + iabs(ey1 - ey2);
        d   = se - ss;
        req = (iabs(d) >= DEADZONE) && (d != 0);
        return {(se < ss), 10'(sx1), 10'(sx2), 9'(sy1), 9'(sy2),
                10'(ex1), 10'(ex2), 9'(ey1), 9'(ey2)};
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-cycle touch strobe; t returns the cycle number of the capturing edge.
    task automatic touch(input logic [1:0] c, input int px1, py1, px2, py2, output int t);
        @(negedge clk);
        touch_valid = 1'b1;
        touch_count = c;
        x1 = px1[9:0];
        y1 = py1[8:0];
        x2 = px2[9:0];
        y2 = py2[8:0];
        @(negedge clk);
        touch_valid = 1'b0;
        t = cyc;
    endtask

    // Full gesture: start sample, end sample, finger-lift with count upc.
    task automatic gesture(input int sx1, sy1, sx2, sy2, input int ex1, ey1, ex2, ey2,
                           input logic [1:0] upc, output int t0);
        bit req;
        logic [W-1:0] e;
        int t;
        e = model(sx1, sy1, sx2, sy2, ex1, ey1, ex2, ey2, req);
        touch(2'd2, sx1, sy1, sx2, sy2, t);
        touch(2'd2, ex1, ey1, ex2, ey2, t);
        if (req) exp_q.push_back(e);
        touch(upc, 0, 0, 0, 0, t0);
    endtask

    task automatic wait_ready(output int t, output bit ok);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (ready) begin ok = 1'b1; t = cyc; end
            else @(negedge clk);
        end
    endtask

    task automatic wait_idle(output int t, output bit ok);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (!busy) begin ok = 1'b1; t = cyc; end
            else @(negedge clk);
        end
    endtask

    // Scoreboard: every oREADY pops one expected request and compares the held outputs.
    always @(negedge clk) begin
        if (ready) begin
            n_assert++;
            assert (!prev_ready) else begin
                n_fail++;
                $error("FAIL ready_width observed=2+cycles expected=1");
            end
            n_assert++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_ready observed=1 expected=0");
            end
            if (exp_q.size() != 0) check("ready_payload", pack_out(), exp_q.pop_front());
        end
        prev_ready = ready;
    end

    initial begin
        int  t0, t1, t;
        bit  ok;
        bit  held;
        logic [W-1:0] a_exp;
        bit  a_req;

        rstn = 1'b0;
        touch_valid = 1'b0;
        touch_count = 2'd0;
        x1 = '0; x2 = '0; y1 = '0; y2 = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_coords", pack_out(), '0);
        check("rst_ready", W'(ready), '0);
        check("rst_busy", W'(busy), '0);
        check("rst_abort", W'(abort_o), '0);
        rstn = 1'b1;

        // IDLE ignores samples that are not two-finger
        touch(2'd1, 10, 10, 20, 20, t);
        touch(2'd3, 10, 10, 20, 20, t);
        check("idle_ignore_busy", W'(busy), '0);
        check("idle_ignore_coords", pack_out(), '0);

        // Pinch out, finger lift with count 1: latency and release timing
        gesture(300, 200, 500, 280, 200, 200, 600, 280, 2'd1, t0);
        check("pinch_out_busy_calc", W'(busy), W'(1));
        wait_ready(t1, ok);
        check("pinch_out_ready_seen", W'(ok), W'(1));
        check("pinch_out_latency", W'(t1 - t0), W'(PIPE_LAT + 1));
        wait_idle(t1, ok);
        check("pinch_out_release", W'(t1 - t0), W'(PIPE_LAT + 2 + COOL_LAT));

        // Pinch in, finger lift with count 0
        gesture(100, 100, 700, 400, 350, 240, 450, 260, 2'd0, t0);
        wait_ready(t1, ok);
        check("pinch_in_ready_seen", W'(ok), W'(1));
        check("pinch_in_zoom_out", W'(zoom_out), W'(1));
        check("pinch_in_busy_issue", W'(busy), W'(1));
        wait_idle(t1, ok);
        check("pinch_in_idle", W'(ok), W'(1));

        // Deadzone: diff 10 rejected, back to IDLE right after CALC
        gesture(0, 0, 200, 100, 0, 0, 210, 100, 2'd1, t0);
        check("dz_reject_calc_busy", W'(busy), W'(1));
        @(negedge clk);
        check("dz_reject_idle", W'(busy), '0);
        repeat (40) @(negedge clk);

        // Deadzone boundary: diff +16 and -16 both issue; count 3 ends the gesture
        gesture(0, 0, 200, 100, 0, 0, 216, 100, 2'd3, t0);
        wait_ready(t1, ok);
        check("dz_plus16_ready", W'(ok), W'(1));
        wait_idle(t1, ok);
        gesture(0, 0, 200, 100, 0, 0, 184, 100, 2'd1, t0);
        wait_ready(t1, ok);
        check("dz_minus16_ready", W'(ok), W'(1));
        wait_idle(t1, ok);

        // Equal spans never issue
        gesture(0, 0, 300, 0, 0, 0, 0, 300, 2'd1, t0);
        repeat (40) @(negedge clk);

        // Busy lockout: strobes during SETTLE and COOL are dropped
        a_exp = model(50, 50, 150, 50, 10, 50, 300, 60, a_req);
        gesture(50, 50, 150, 50, 10, 50, 300, 60, 2'd1, t0);
        repeat (4) @(negedge clk);
        touch(2'd2, 700, 400, 20, 30, t);
        touch(2'd1, 0, 0, 0, 0, t);
        wait_ready(t1, ok);
        check("lockout_ready", W'(ok), W'(1));
        touch(2'd2, 600, 300, 40, 50, t);
        touch(2'd1, 0, 0, 0, 0, t);
        repeat (5) @(negedge clk);
        check("lockout_idle", W'(busy), '0);
        check("lockout_coords_held", pack_out(), a_exp);

        // Fresh gesture after lockout is accepted
        gesture(100, 100, 700, 400, 350, 240, 450, 260, 2'd0, t0);
        wait_ready(t1, ok);
        check("fresh_ready", W'(ok), W'(1));
        wait_idle(t1, ok);

        // Reset while SETTLE counter is 10: everything clears, no request ever
        touch(2'd2, 300, 200, 500, 280, t);
        touch(2'd2, 200, 200, 600, 280, t);
        touch(2'd1, 0, 0, 0, 0, t0);
        repeat (11) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("mid_rst_coords", pack_out(), '0);
        check("mid_rst_busy", W'(busy), '0);
        check("mid_rst_ready", W'(ready), '0);
        rstn = 1'b1;
        repeat (40) @(negedge clk);

        // Single sample then silence
        touch(2'd2, 300, 200, 500, 280, t0);
`ifdef ZOOM_TIMEOUT_EN
        ok = 1'b0;
        t1 = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (abort_o) begin ok = 1'b1; t1 = cyc; end
            else @(negedge clk);
        end
        check("timeout_abort_seen", W'(ok), W'(1));
        check("timeout_abort_cycle", W'(t1 - t0), W'(TIMEOUT));
        @(negedge clk);
        check("timeout_abort_width", W'(abort_o), '0);
        check("timeout_idle", W'(busy), '0);
`else
        held = 1'b1;
        for (int i = 0; i < 3 * TIMEOUT; i++) begin
            @(negedge clk);
            if (!busy || abort_o) held = 1'b0;
        end
        check("no_timeout_track_held", W'(held), W'(1));
`endif

        check("queue_drained", W'(exp_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
